// File: rtl/neopixel_rx.sv
// NeoPixel (WS2812-style) single-wire stream decoder.
// Measures pulse widths, assembles LSB-first bytes, publishes frames after a reset gap.
module neopixel_rx #(
  parameter int NUM_BYTES    = 48,
  parameter int POL          = 0,
  parameter int MIN_PULSE    = 2,
  parameter int BIT_THRESH   = 12,
  parameter int MAX_PULSE    = 200,
  parameter int RESET_CYCLES = 1000
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   din,
  output logic [8*NUM_BYTES-1:0] framebuf,
  output logic                   frame_valid,
  output logic                   frame_error,
  output logic [7:0]             byte_data,
  output logic                   byte_valid
);

  localparam int LW = $clog2(RESET_CYCLES + 1);
  localparam int BW = $clog2(NUM_BYTES + 1);
  localparam logic [LW-1:0] LO_LAST = LW'(RESET_CYCLES - 1);
  localparam logic [LW-1:0] LO_END  = LW'(RESET_CYCLES);
  localparam logic [BW-1:0] NB      = BW'(NUM_BYTES);
  localparam logic [7:0]    W_MIN   = 8'(MIN_PULSE);
  localparam logic [7:0]    W_MAX   = 8'(MAX_PULSE);
  localparam logic [7:0]    W_ONE   = 8'(BIT_THRESH);
  localparam logic          PL      = (POL != 0);

  typedef enum logic [1:0] {
    WAIT_GAP,
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t state;

  logic s1, s2, s_d;
  logic s, rise;

  logic [7:0]             hi_cnt;
  logic [LW-1:0]          lo_cnt;
  logic [2:0]             bit_cnt;
  logic [BW-1:0]          byte_idx;
  logic                   err;
  logic [7:0]             shift_reg;
  logic [8*NUM_BYTES-1:0] shadow;

  logic       bit_v;
  logic       w_bad;
  logic       frame_ok;
  logic [7:0] shift_nx;

  // Synchronizer resets to the idle level so no false edge follows reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1  <= PL;
      s2  <= PL;
      s_d <= 1'b0;
    end else begin
      s1  <= din;
      s2  <= s1;
      s_d <= s;
    end
  end

  assign s        = s2 ^ PL;
  assign rise     = s & ~s_d;
  assign bit_v    = (hi_cnt >= W_ONE);
  assign w_bad    = (hi_cnt < W_MIN) || (hi_cnt > W_MAX);
  assign shift_nx = {bit_v, shift_reg[7:1]};
  assign frame_ok = !err && (bit_cnt == 3'd0) && (byte_idx == NB);

  // Decoder FSM: pulse measurement, byte assembly and frame publication
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= WAIT_GAP;
      hi_cnt      <= '0;
      lo_cnt      <= '0;
      bit_cnt     <= '0;
      byte_idx    <= '0;
      err         <= 1'b0;
      shift_reg   <= '0;
      shadow      <= '0;
      framebuf    <= '0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      byte_valid  <= 1'b0;
      unique case (state)
        WAIT_GAP: begin
          if (s) begin
            lo_cnt <= '0;
          end else if (lo_cnt == LO_LAST) begin
            lo_cnt   <= LO_END;
            bit_cnt  <= '0;
            byte_idx <= '0;
            err      <= 1'b0;
            state    <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (rise) begin
            hi_cnt <= 8'd1;
            state  <= HIGH;
          end
        end
        HIGH: begin
          if (s) begin
            if (hi_cnt != 8'hFF) hi_cnt <= hi_cnt + 8'd1;
          end else begin
            if (w_bad) begin
              err <= 1'b1;
            end else begin
              shift_reg <= shift_nx;
              if (bit_cnt == 3'd7) begin
                bit_cnt    <= '0;
                byte_data  <= shift_nx;
                byte_valid <= 1'b1;
                if (byte_idx < NB) begin
                  shadow[{byte_idx, 3'b000} +: 8] <= shift_nx;
                  byte_idx <= byte_idx + 1'b1;
                end else begin
                  err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
            lo_cnt <= {{(LW-1){1'b0}}, 1'b1};
            state  <= LOW;
          end
        end
        LOW: begin
          if (rise) begin
            hi_cnt <= 8'd1;
            state  <= HIGH;
          end else if (lo_cnt == LO_LAST) begin
            if (frame_ok) begin
              framebuf    <= shadow;
              frame_valid <= 1'b1;
            end else begin
              frame_error <= 1'b1;
            end
            lo_cnt   <= LO_END;
            bit_cnt  <= '0;
            byte_idx <= '0;
            err      <= 1'b0;
            state    <= IDLE;
          end else begin
            lo_cnt <= lo_cnt + 1'b1;
          end
        end
        default: state <= WAIT_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_neopixel_rx.sv
// Directed bench for neopixel_rx: frames, bit decode, errors, reset, inverted line.
// Two instances share the stimulus; the second sees the inverted line with POL=1.
module tb_neopixel_rx;

  localparam int NB = 48;
  localparam int FW = 8 * NB;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic din = 1'b0;
  logic din_n;

  logic [FW-1:0] fb0, fb1;
  logic fv0, fe0, bv0, fv1, fe1, bv1;
  logic [7:0] bd0, bd1;

  int checks = 0;
  int failures = 0;

  int bv_cnt = 0, fv_cnt = 0, fe_cnt = 0;
  int fv1_cnt = 0, fe1_cnt = 0;
  int fb_viol = 0, coinc = 0;
  logic [7:0] last_byte = 8'h00;
  logic [FW-1:0] fb_prev = '0;
  logic nrst_prev = 1'b0;

  logic [FW-1:0] exp_a, exp_c;

  always #5 clk = ~clk;
  assign din_n = ~din;

  neopixel_rx #(.NUM_BYTES(NB), .POL(0)) u0 (
    .clk(clk), .nrst(nrst), .din(din),
    .framebuf(fb0), .frame_valid(fv0), .frame_error(fe0),
    .byte_data(bd0), .byte_valid(bv0)
  );

  neopixel_rx #(.NUM_BYTES(NB), .POL(1)) u1 (
    .clk(clk), .nrst(nrst), .din(din_n),
    .framebuf(fb1), .frame_valid(fv1), .frame_error(fe1),
    .byte_data(bd1), .byte_valid(bv1)
  );

  // Event counters sampled away from the active edge
  always @(negedge clk) begin
    if (bv0) begin
      bv_cnt <= bv_cnt + 1;
      last_byte <= bd0;
    end
    if (fv0) fv_cnt <= fv_cnt + 1;
    if (fe0) fe_cnt <= fe_cnt + 1;
    if (fv1) fv1_cnt <= fv1_cnt + 1;
    if (fe1) fe1_cnt <= fe1_cnt + 1;
    if (bv0 && (fv0 || fe0)) coinc <= coinc + 1;
    if (nrst && nrst_prev && !fv0 && fb0 !== fb_prev)
      fb_viol <= fb_viol + 1;
    fb_prev <= fb0;
    nrst_prev <= nrst;
  end

  task automatic chk(input string tag, input logic [FW-1:0] got,
                     input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int period);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(period - hi);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) pulse(b[i] ? 16 : 8, 25);
  endtask

  task automatic gap();
    din = 1'b0;
    tick(1010);
  endtask

  int b0, f0, e0, g0;

  initial begin
    for (int k = 0; k < NB; k++) begin
      exp_a[8*k +: 8] = 8'(k);
      exp_c[8*k +: 8] = 8'(k * 7 + 3);
    end

    tick(3);
    @(negedge clk);
    chk("rst_framebuf", fb0, '0);
    chk("rst_flags", FW'({fv0, fe0, bv0}), '0);
    chk("rst_byte_data", FW'(bd0), '0);
    @(posedge clk);
    #1 nrst = 1'b1;

    f0 = fv_cnt; e0 = fe_cnt;
    gap();
    chk("gap_only_no_pulse", FW'((fv_cnt - f0) + (fe_cnt - e0)), '0);

    b0 = bv_cnt; f0 = fv_cnt; e0 = fe_cnt; g0 = fv1_cnt;
    for (int k = 0; k < NB; k++) send_byte(8'(k));
    gap();
    chk("full_bytes", FW'(bv_cnt - b0), FW'(48));
    chk("full_fv", FW'(fv_cnt - f0), FW'(1));
    chk("full_fe", FW'(fe_cnt - e0), '0);
    chk("full_fb", fb0, exp_a);
    chk("full_fb_lo", FW'(fb0[7:0]), FW'(8'h00));
    chk("full_fb_hi", FW'(fb0[383:376]), FW'(8'h2F));
    chk("full_last_byte", FW'(last_byte), FW'(8'h2F));
    chk("pol1_fv", FW'(fv1_cnt - g0), FW'(1));
    chk("pol1_fb", fb1, exp_a);

    b0 = bv_cnt; f0 = fv_cnt; e0 = fe_cnt;
    send_byte(8'hA5);
    gap();
    chk("dec_bytes", FW'(bv_cnt - b0), FW'(1));
    chk("dec_a5", FW'(last_byte), FW'(8'hA5));
    chk("dec_fe", FW'(fe_cnt - e0), FW'(1));
    chk("dec_fv", FW'(fv_cnt - f0), '0);

    f0 = fv_cnt; e0 = fe_cnt;
    for (int k = 0; k < 47; k++) send_byte(8'hFF - 8'(k));
    gap();
    chk("short_fe", FW'(fe_cnt - e0), FW'(1));
    chk("short_fv", FW'(fv_cnt - f0), '0);
    chk("short_fb", fb0, exp_a);

    b0 = bv_cnt; f0 = fv_cnt; e0 = fe_cnt;
    for (int k = 0; k < 49; k++) send_byte(8'hFF - 8'(k));
    gap();
    chk("ovf_bytes", FW'(bv_cnt - b0), FW'(49));
    chk("ovf_fe", FW'(fe_cnt - e0), FW'(1));
    chk("ovf_fv", FW'(fv_cnt - f0), '0);
    chk("ovf_fb", fb0, exp_a);

    b0 = bv_cnt; f0 = fv_cnt; e0 = fe_cnt;
    for (int k = 0; k < NB; k++) begin
      send_byte(8'hFF - 8'(k));
      if (k == 10) pulse(1, 25);
    end
    gap();
    chk("glitch_bytes", FW'(bv_cnt - b0), FW'(48));
    chk("glitch_fe", FW'(fe_cnt - e0), FW'(1));
    chk("glitch_fv", FW'(fv_cnt - f0), '0);
    chk("glitch_fb", fb0, exp_a);

    f0 = fv_cnt; e0 = fe_cnt;
    for (int k = 0; k < NB; k++) begin
      send_byte(8'hFF - 8'(k));
      if (k == 20) pulse(300, 325);
    end
    gap();
    chk("long_fe", FW'(fe_cnt - e0), FW'(1));
    chk("long_fv", FW'(fv_cnt - f0), '0);
    chk("long_fb", fb0, exp_a);

    for (int k = 0; k < 20; k++) send_byte(8'h33);
    nrst = 1'b0;
    tick(1);
    nrst = 1'b1;
    @(negedge clk);
    chk("mid_rst_fb", fb0, '0);
    chk("mid_rst_bd", FW'(bd0), '0);
    chk("mid_rst_flags", FW'({fv0, fe0, bv0}), '0);
    #1;
    b0 = bv_cnt; f0 = fv_cnt; e0 = fe_cnt;
    for (int k = 0; k < 4; k++) send_byte(8'hC3);
    chk("post_rst_ignored", FW'(bv_cnt - b0), '0);
    gap();
    chk("post_rst_gap_quiet", FW'((fv_cnt - f0) + (fe_cnt - e0)), '0);
    b0 = bv_cnt; f0 = fv_cnt; g0 = fv1_cnt;
    for (int k = 0; k < NB; k++) send_byte(8'(k * 7 + 3));
    gap();
    chk("clean_bytes", FW'(bv_cnt - b0), FW'(48));
    chk("clean_fv", FW'(fv_cnt - f0), FW'(1));
    chk("clean_fe", FW'(fe_cnt - e0), '0);
    chk("clean_fb", fb0, exp_c);
    chk("pol1_clean_fv", FW'(fv1_cnt - g0), FW'(1));
    chk("pol1_clean_fb", fb1, exp_c);
    chk("pol1_no_err", FW'(fe1_cnt), FW'(fe_cnt));

    chk("fb_stable", FW'(fb_viol), '0);
    chk("bv_fv_apart", FW'(coinc), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
